// File: rtl/speech_sample_player.sv
// Plays 8-bit samples unpacked from a range of 32-bit flash words, one per synchronised sample tick.
// Flash read handshake: a read is accepted in any cycle with flash_read=1 and flash_waitrequest=0; flash_addr is held stable until then.
module speech_sample_player #(
  parameter int          ADDR_W  = 23,
  parameter logic [7:0]  SILENCE = 8'h80
) (
  input  logic              clk_input,
  input  logic              reset_n,
  input  logic              sample_clk,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [7:0]        audio_out,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_PLAY      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_sync1, r_sync2, r_sync_edge, r_tick;
  logic              r_pending;
  logic [1:0]        r_idx;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_cur, r_end;
  logic              r_flash_read;
  logic [ADDR_W-1:0] r_flash_addr;
  logic [7:0]        r_audio;
  logic              r_busy, r_done, r_underrun;
  logic              w_accept;
  logic [7:0]        w_byte;

  assign w_accept   = r_flash_read & ~flash_waitrequest;
  assign flash_read = r_flash_read;
  assign flash_addr = r_flash_addr;
  assign audio_out  = r_audio;
  assign busy       = r_busy;
  assign done       = r_done;
  assign underrun   = r_underrun;
  assign dbg_state  = r_state;

  always_comb begin
    w_byte = r_word[7:0];
    case (r_idx)
      2'd1:    w_byte = r_word[15:8];
      2'd2:    w_byte = r_word[23:16];
      2'd3:    w_byte = r_word[31:24];
      default: w_byte = r_word[7:0];
    endcase
  end

  // Tick is registered from the edge detector, so it lands on the third clk edge after sample_clk rises.
  always_ff @(posedge clk_input or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_edge <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_sync1     <= sample_clk;
      r_sync2     <= r_sync1;
      r_sync_edge <= r_sync2;
      r_tick      <= r_sync2 & ~r_sync_edge;
    end
  end

  always_ff @(posedge clk_input or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_pending    <= 1'b0;
      r_idx        <= 2'd0;
      r_word       <= 32'd0;
      r_cur        <= '0;
      r_end        <= '0;
      r_flash_read <= 1'b0;
      r_flash_addr <= '0;
      r_audio      <= SILENCE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // One tick may wait while the next word is fetched; a second one is lost.
      if (r_tick && (r_state == S_FETCH || r_state == S_WAIT_DATA)) begin
        if (r_pending) r_underrun <= 1'b1;
        else           r_pending  <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (start) begin
            r_cur      <= start_addr;
            r_end      <= end_addr;
            r_underrun <= 1'b0;
            r_pending  <= 1'b0;
            r_busy     <= 1'b1;
            if (end_addr < start_addr) begin
              r_state <= S_DONE;
            end else begin
              r_state      <= S_FETCH;
              r_flash_read <= 1'b1;
              r_flash_addr <= start_addr;
            end
          end
        end
        S_FETCH: begin
          if (w_accept) begin
            r_flash_read <= 1'b0;
            if (flash_readdatavalid) begin
              r_word  <= flash_readdata;
              r_idx   <= 2'd0;
              r_state <= S_PLAY;
            end else begin
              r_state <= S_WAIT_DATA;
            end
          end
        end
        S_WAIT_DATA: begin
          if (flash_readdatavalid) begin
            r_word  <= flash_readdata;
            r_idx   <= 2'd0;
            r_state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (r_tick || r_pending) begin
            r_audio   <= w_byte;
            r_pending <= r_tick & r_pending;
            r_idx     <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              if (r_cur == r_end) begin
                r_state <= S_DONE;
              end else begin
                r_cur        <= r_cur + ADDR_W'(1);
                r_flash_read <= 1'b1;
                r_flash_addr <= r_cur + ADDR_W'(1);
                r_state      <= S_FETCH;
              end
            end
          end
        end
        S_DONE: begin
          r_done    <= 1'b1;
          r_audio   <= SILENCE;
          r_pending <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_speech_sample_player.sv
// Randomised bench for speech_sample_player: flash responder, async sample clock, scoreboard of reads and samples.
module tb_speech_sample_player;

  logic        clk_input = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_clk = 1'b0;
  logic        start = 1'b0;
  logic [22:0] start_addr = '0;
  logic [22:0] end_addr = '0;
  logic        flash_read;
  logic [22:0] flash_addr;
  logic        flash_waitrequest = 1'b1;
  logic [31:0] flash_readdata = '0;
  logic        flash_readdatavalid = 1'b0;
  logic [7:0]  audio_out;
  logic        busy, done, underrun;
  logic [2:0]  dbg_state;

  speech_sample_player dut (
    .clk_input(clk_input), .reset_n(reset_n), .sample_clk(sample_clk),
    .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .flash_read(flash_read), .flash_addr(flash_addr),
    .flash_waitrequest(flash_waitrequest), .flash_readdata(flash_readdata),
    .flash_readdatavalid(flash_readdatavalid), .audio_out(audio_out),
    .busy(busy), .done(done), .underrun(underrun), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_input = ~clk_input;

  int half_ns = 320;
  initial begin
    #3;
    forever begin
      #(half_ns);
      sample_clk = ~sample_clk;
    end
  end

  initial begin
    #(800_000);
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];
  logic [22:0] addr_q[$];
  logic [31:0] mem [int];
  int          cfg_stall = 0;
  int          cfg_lat = 2;
  int          rd_cnt = 0;
  int          smp_cnt = 0;
  int          done_cnt = 0;
  int          exp_words = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- flash responder ----------------
  initial begin : responder
    logic [22:0] addr_l;
    forever begin
      @(posedge clk_input); #1;
      flash_readdatavalid = 1'b0;
      if (reset_n && flash_read) begin
        repeat (cfg_stall) begin @(posedge clk_input); #1; end
        flash_waitrequest = 1'b0;
        addr_l = flash_addr;
        if (cfg_lat == 0) begin
          flash_readdatavalid = 1'b1;
          flash_readdata = mem[int'(addr_l)];
        end
        @(posedge clk_input); #1;
        flash_waitrequest = 1'b1;
        flash_readdatavalid = 1'b0;
        if (cfg_lat > 0) begin
          repeat (cfg_lat - 1) begin @(posedge clk_input); #1; end
          flash_readdatavalid = 1'b1;
          flash_readdata = mem[int'(addr_l)];
          @(posedge clk_input); #1;
          flash_readdatavalid = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [7:0]  prev_audio = 8'h80;
  logic        prev_stall = 1'b0;
  logic [22:0] stall_addr = '0;

  always @(negedge clk_input) begin
    if (!reset_n) begin
      prev_audio = audio_out;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_read_held", flash_read, 1);
        chk("stall_addr_stable", flash_addr, stall_addr);
      end
      prev_stall = flash_read && flash_waitrequest;
      stall_addr = flash_addr;
      if (flash_read && !flash_waitrequest) begin
        rd_cnt++;
        total++;
        if (addr_q.size() == 0) begin
          bad++;
          $display("FAIL read_extra: got read at %h expected no read", flash_addr);
        end else begin
          total--;
          chk("read_addr", flash_addr, addr_q.pop_front());
        end
      end
      if (audio_out != prev_audio) begin
        if (audio_out == 8'h80) begin
          chk("silence_samples_left", exp_q.size(), 0);
          chk("silence_with_done", done, 1);
        end else begin
          smp_cnt++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sample_extra: got %h expected none", audio_out);
          end else begin
            total--;
            chk("sample", audio_out, exp_q.pop_front());
          end
        end
        prev_audio = audio_out;
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- reference model and drivers ----------------
  // Each range yields its words in address order, each word split low byte first.
  task automatic setup_range(input logic [22:0] s, input logic [22:0] e,
                             input bit use_fixed, input logic [31:0] fixed_w);
    logic [22:0] a;
    logic [31:0] w;
    logic [7:0]  b, prev_b;
    exp_words = (e < s) ? 0 : int'(e - s) + 1;
    a = s;
    prev_b = 8'h80;
    for (int i = 0; i < exp_words; i++) begin
      if (use_fixed) begin
        w = fixed_w;
      end else begin
        for (int k = 0; k < 4; k++) begin
          do b = 8'($urandom_range(0, 255)); while (b == prev_b || b == 8'h80);
          w[8*k +: 8] = b;
          prev_b = b;
        end
      end
      mem[int'(a)] = w;
      addr_q.push_back(a);
      for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
      a = a + 23'd1;
    end
  endtask

  task automatic pulse_start(input logic [22:0] s, input logic [22:0] e);
    @(posedge clk_input); #1;
    start = 1'b1; start_addr = s; end_addr = e;
    @(posedge clk_input); #1;
    start = 1'b0;
  endtask

  task automatic kick(input logic [22:0] s, input logic [22:0] e, input int stall, input int lat,
                      input int half, input bit use_fixed, input logic [31:0] fixed_w);
    cfg_stall = stall; cfg_lat = lat; half_ns = half;
    setup_range(s, e, use_fixed, fixed_w);
    rd_cnt = 0; smp_cnt = 0;
    pulse_start(s, e);
  endtask

  task automatic finish_range(input int budget, input logic exp_ur);
    int c, d0;
    d0 = done_cnt;
    c = 0;
    do begin @(negedge clk_input); c++; end while (done !== 1'b1 && c < budget);
    chk("done_seen", done, 1);
    chk("done_audio_silence", audio_out, 8'h80);
    chk("done_busy_still_high", busy, 1);
    @(negedge clk_input);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    repeat (3) @(negedge clk_input);
    chk("read_count", rd_cnt, exp_words);
    chk("sample_count", smp_cnt, 4 * exp_words);
    chk("samples_left", exp_q.size(), 0);
    chk("reads_left", addr_q.size(), 0);
    chk("underrun", underrun, exp_ur);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int c, fr;
    logic [22:0] s;
    repeat (3) @(posedge clk_input);
    #1;
    chk("rst_audio", audio_out, 8'h80);
    chk("rst_busy", busy, 0);
    chk("rst_flash_read", flash_read, 0);
    chk("rst_flash_addr", flash_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    reset_n = 1'b1;
    repeat (4) @(posedge clk_input);

    // single word, fixed data, 2-cycle latency
    kick(23'h10, 23'h10, 0, 2, 320, 1'b1, 32'hA1B2C3D4);
    finish_range(2000, 1'b0);

    // three words with five stall cycles per read
    kick(23'h20, 23'h22, 5, 1, 320, 1'b0, 32'h0);
    finish_range(5000, 1'b0);

    // fast sample clock against slow flash
    kick(23'h30, 23'h31, 0, 30, 40, 1'b0, 32'h0);
    finish_range(2000, 1'b1);

    // empty range
    kick(23'h50, 23'h4F, 0, 2, 320, 1'b0, 32'h0);
    finish_range(2, 1'b0);

    // second start while busy must be ignored
    kick(23'h60, 23'h61, 1, 2, 320, 1'b0, 32'h0);
    repeat (30) @(posedge clk_input);
    pulse_start(23'h70, 23'h70);
    finish_range(4000, 1'b0);

    // top of the address space
    kick(23'h7FFFFF, 23'h7FFFFF, 0, 0, 320, 1'b0, 32'h0);
    finish_range(2000, 1'b0);

    // random ranges, latencies and stalls
    for (int t = 0; t < 6; t++) begin
      s = 23'($urandom_range(0, 23'h7FFFFD));
      kick(s, s + 23'($urandom_range(0, 2)), $urandom_range(0, 3),
           (t == 0) ? 0 : $urandom_range(0, 4), $urandom_range(400, 800), 1'b0, 32'h0);
      finish_range(8000, 1'b0);
    end

    // asynchronous reset in the middle of playback
    kick(23'h90, 23'h91, 0, 2, 320, 1'b0, 32'h0);
    c = 0;
    while (smp_cnt < 2 && c < 3000) begin @(negedge clk_input); c++; end
    chk("reached_play", (smp_cnt >= 2), 1);
    @(posedge clk_input); #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_audio", audio_out, 8'h80);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_flash_read", flash_read, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(posedge clk_input);
    #1;
    reset_n = 1'b1;
    fr = 0;
    repeat (20) begin
      @(negedge clk_input);
      if (flash_read) fr++;
    end
    chk("post_rst_no_read", fr, 0);
    chk("post_rst_state_idle", dbg_state, 0);
    chk("post_rst_audio", audio_out, 8'h80);
    chk("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
